// File: rtl/cpu_run_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_run_ctrl_pkg : shared types and constants for the run sequencer |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

`ifndef CPU_WORD_W
`define CPU_WORD_W 32
`endif

package cpu_run_ctrl_pkg;

  localparam int C_WORD       = `CPU_WORD_W;
  localparam int C_MAX_CYCLES = 1000000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CPU_RST = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4,
    S_TIMEOUT = 3'd5,
    S_ERROR   = 3'd6
  } run_state_t;

endpackage

`default_nettype wire

// File: rtl/cpu_run_ctrl_loader_if.sv
// +--------------------------------------------------------------------+
// | cpu_run_ctrl_loader_if : program-load handshake and imem write     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module cpu_run_ctrl_loader_if
  import cpu_run_ctrl_pkg::*;
#(
  parameter int WORD       = C_WORD,
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              clear,
  input  logic              ld_valid,
  input  logic [WORD-1:0]   ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD-1:0]   imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              hs_last,
  output logic              hs_overflow
);

  localparam logic [ADDR_W:0] c_last_addr = (ADDR_W+1)'(IMEM_DEPTH - 1);

  logic [ADDR_W:0] r_word_count;
  logic            w_hs;

  assign w_hs        = active & ld_valid;
  assign ld_ready    = active;
  assign imem_we     = w_hs;
  assign imem_addr   = r_word_count[ADDR_W-1:0];
  assign imem_wdata  = ld_data;
  assign word_count  = r_word_count;
  assign hs_last     = w_hs & ld_last;
  // The top slot is still written; the controller errors out afterwards.
  assign hs_overflow = w_hs & ~ld_last & (r_word_count == c_last_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_count <= '0;
    end else if (clear) begin
      r_word_count <= '0;
    end else if (w_hs) begin
      r_word_count <= r_word_count + (ADDR_W+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// +--------------------------------------------------------------------+
// | cpu_run_ctrl : loads a program, resets and runs the core to finish |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int WORD       = C_WORD,
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH),
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = C_MAX_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [WORD-1:0]   ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD-1:0]   imem_wdata,
  output logic              cpu_rst_n,
  output logic              cpu_en,
  input  logic              cpu_finish,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              load_err,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [CNT_W-1:0] c_last_cycle = CNT_W'(MAX_CYCLES - 1);

  run_state_t       r_state;
  run_state_t       w_state_nxt;
  logic             r_cpu_rst_n;
  logic             r_cpu_en;
  logic [CNT_W-1:0] r_cycle_count;
  logic             w_cpu_rst_n_nxt;
  logic             w_cpu_en_nxt;
  logic             w_startable;
  logic             w_start_ok;
  logic             w_load_active;
  logic             w_run_count;
  logic             w_hs_last;
  logic             w_hs_overflow;

  assign w_startable   = (r_state == S_IDLE) || (r_state == S_DONE) ||
                         (r_state == S_TIMEOUT) || (r_state == S_ERROR);
  assign w_start_ok    = start & ~abort & w_startable;
  assign w_load_active = (r_state == S_LOAD) & ~abort;
  // An aborted RUN cycle is not counted so the count reflects completed work.
  assign w_run_count   = (r_state == S_RUN) & ~abort;

  cpu_run_ctrl_loader_if #(
    .WORD       (WORD),
    .IMEM_DEPTH (IMEM_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_loader (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (w_load_active),
    .clear       (w_start_ok),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .word_count  (word_count),
    .hs_last     (w_hs_last),
    .hs_overflow (w_hs_overflow)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_TIMEOUT, S_ERROR: begin
          if (start) w_state_nxt = S_LOAD;
        end
        S_LOAD: begin
          if (w_hs_last)          w_state_nxt = S_CPU_RST;
          else if (w_hs_overflow) w_state_nxt = S_ERROR;
        end
        S_CPU_RST: w_state_nxt = S_RUN;
        S_RUN: begin
          if (cpu_finish)                          w_state_nxt = S_DONE;
          else if (r_cycle_count == c_last_cycle)  w_state_nxt = S_TIMEOUT;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    // Core controls are registered from the state being entered.
    w_cpu_rst_n_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_DONE) ||
                      (w_state_nxt == S_TIMEOUT);
    w_cpu_en_nxt    = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cpu_rst_n   <= 1'b0;
      r_cpu_en      <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_rst_n <= w_cpu_rst_n_nxt;
      r_cpu_en    <= w_cpu_en_nxt;
      if (w_start_ok) begin
        r_cycle_count <= '0;
      end else if (w_run_count) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
    end
  end

  assign cpu_rst_n   = r_cpu_rst_n;
  assign cpu_en      = r_cpu_en;
  assign cycle_count = r_cycle_count;
  assign busy        = (r_state == S_LOAD) || (r_state == S_CPU_RST) || (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign timeout     = (r_state == S_TIMEOUT);
  assign load_err    = (r_state == S_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_cpu_run_ctrl : directed bench for the run sequencer             |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_cpu_run_ctrl;

  localparam int c_word   = 32;
  localparam int c_depth  = 8;
  localparam int c_addr_w = 3;
  localparam int c_cnt_w  = 32;
  localparam int c_max    = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                abort;
  logic                ld_valid;
  logic                ld_ready;
  logic [c_word-1:0]   ld_data;
  logic                ld_last;
  logic                imem_we;
  logic [c_addr_w-1:0] imem_addr;
  logic [c_word-1:0]   imem_wdata;
  logic                cpu_rst_n;
  logic                cpu_en;
  logic                cpu_finish;
  logic                busy;
  logic                done;
  logic                timeout;
  logic                load_err;
  logic [c_cnt_w-1:0]  cycle_count;
  logic [c_addr_w:0]   word_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          en_cnt;
  logic        en_seen;
  logic [31:0] prog [0:7];

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .WORD       (c_word),
    .IMEM_DEPTH (c_depth),
    .ADDR_W     (c_addr_w),
    .CNT_W      (c_cnt_w),
    .MAX_CYCLES (c_max)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_rst_n   (cpu_rst_n),
    .cpu_en      (cpu_en),
    .cpu_finish  (cpu_finish),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .load_err    (load_err),
    .cycle_count (cycle_count),
    .word_count  (word_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load_word(input int idx, input logic [31:0] data, input logic last);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    #1;
    check("imem_we", 64'(imem_we), 64'(1));
    check("imem_addr", 64'(imem_addr), 64'(idx));
    check("imem_wdata", 64'(imem_wdata), 64'(data));
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Runs the core, raising finish on the fin_at-th enabled cycle (0 = never).
  task automatic run_core(input int fin_at, input int start_at);
    en_cnt = 0;
    for (int k = 0; k < 60 && busy; k++) begin
      if (cpu_en) en_cnt++;
      cpu_finish = cpu_en && (en_cnt == fin_at);
      start      = (k == start_at);
      step();
      cpu_finish = 1'b0;
      start      = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) prog[i] = 32'hC0DE0000 ^ (32'(i) * 32'h01010101);
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    cpu_finish = 1'b0;
    #3;
    check("rst cpu_rst_n", 64'(cpu_rst_n), 64'(0));
    check("rst cpu_en", 64'(cpu_en), 64'(0));
    check("rst cycle_count", 64'(cycle_count), 64'(0));
    check("rst word_count", 64'(word_count), 64'(0));
    check("rst flags", 64'({busy, done, timeout, load_err, ld_ready}), 64'(0));
    #9 rst_n = 1'b1;
    step();

    // Basic load of 4 words, finish on 10th enabled cycle
    pulse_start();
    check("load busy", 64'(busy), 64'(1));
    #1;
    check("load ld_ready", 64'(ld_ready), 64'(1));
    for (int i = 0; i < 4; i++) load_word(i, prog[i], i == 3);
    check("cpurst cpu_rst_n", 64'(cpu_rst_n), 64'(0));
    check("cpurst cpu_en", 64'(cpu_en), 64'(0));
    check("cpurst word_count", 64'(word_count), 64'(4));
    step();
    check("run cpu_rst_n", 64'(cpu_rst_n), 64'(1));
    check("run cpu_en", 64'(cpu_en), 64'(1));
    run_core(10, -1);
    check("b done", 64'(done), 64'(1));
    check("b cpu_en after finish", 64'(cpu_en), 64'(0));
    check("b cpu_rst_n held", 64'(cpu_rst_n), 64'(1));
    check("b cycle_count", 64'(cycle_count), 64'(10));
    check("b enabled cycles", 64'(en_cnt), 64'(10));
    check("b word_count", 64'(word_count), 64'(4));

    // Gapped load, start during RUN ignored, no finish -> timeout
    pulse_start();
    check("g cycle_count clr", 64'(cycle_count), 64'(0));
    check("g word_count clr", 64'(word_count), 64'(0));
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < 3; g++) begin
        #1;
        check("g gap no we", 64'(imem_we), 64'(0));
        step();
      end
      load_word(i, prog[i+4], i == 2);
    end
    check("g word_count", 64'(word_count), 64'(3));
    step();
    run_core(0, 3);
    check("t timeout", 64'(timeout), 64'(1));
    check("t done", 64'(done), 64'(0));
    check("t cycle_count", 64'(cycle_count), 64'(16));
    check("t cpu_en", 64'(cpu_en), 64'(0));
    step();
    step();
    check("t frozen", 64'(cycle_count), 64'(16));

    // Finish coinciding with the last budget cycle
    pulse_start();
    load_word(0, prog[7], 1'b1);
    step();
    run_core(16, -1);
    check("f done", 64'(done), 64'(1));
    check("f timeout", 64'(timeout), 64'(0));
    check("f cycle_count", 64'(cycle_count), 64'(16));

    // Overflow: 8 words without ld_last
    pulse_start();
    for (int i = 0; i < 8; i++) load_word(i, prog[i], 1'b0);
    check("e load_err", 64'(load_err), 64'(1));
    check("e word_count", 64'(word_count), 64'(8));
    en_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en_seen = en_seen | cpu_en | cpu_rst_n;
      step();
    end
    check("e core held", 64'(en_seen), 64'(0));
    check("e still err", 64'(load_err), 64'(1));

    // Abort mid-run at cycle_count 5
    pulse_start();
    load_word(0, prog[1], 1'b0);
    load_word(1, prog[2], 1'b1);
    step();
    for (int k = 0; k < 20 && cycle_count != 5; k++) step();
    check("a reached 5", 64'(cycle_count), 64'(5));
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("a idle", 64'({busy, done, timeout, load_err}), 64'(0));
    check("a cpu_en", 64'(cpu_en), 64'(0));
    check("a cpu_rst_n", 64'(cpu_rst_n), 64'(0));
    check("a cycle_count", 64'(cycle_count), 64'(5));
    check("a word_count", 64'(word_count), 64'(2));
    pulse_start();
    check("a restart cycles", 64'(cycle_count), 64'(0));
    check("a restart words", 64'(word_count), 64'(0));
    load_word(0, prog[3], 1'b0);

    // Asynchronous reset mid-load, between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    check("r busy", 64'(busy), 64'(0));
    check("r ld_ready", 64'(ld_ready), 64'(0));
    check("r word_count", 64'(word_count), 64'(0));
    check("r core", 64'({cpu_en, cpu_rst_n}), 64'(0));
    #2 rst_n = 1'b1;
    step();
    check("r stays idle", 64'(busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
